// File: rtl/lod_norm_pipe.sv
// Two-stage leading/trailing-one detector and normaliser, 2-cycle latency.
// Valid/ready at both ends; a stage loads when it is empty or its successor drains.
module lod_norm_pipe #(
   parameter int W = 12,
   parameter int G = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W-1:0]         frac_i,
   input  logic                 mode_i,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [$clog2(W)-1:0] idx_o,
   output logic [W-1:0]         norm_o,
   output logic                 zero_o
);
   localparam int IW  = $clog2(W);
   localparam int NG  = W / G;
   localparam int GIW = (NG > 1) ? $clog2(NG) : 1;
   localparam int BW  = (G > 1) ? $clog2(G) : 1;

   typedef struct packed {
      logic [NG-1:0]  grp_or;
      logic [G-1:0]   grp_bits;
      logic [GIW-1:0] grp_idx;
      logic [W-1:0]   frac;
      logic           mode;
   } s1_t;

   s1_t           s1_d, s1_q;
   logic          s1_vld_q, s2_vld_q;
   logic          adv1, adv2;
   logic [BW-1:0] bit_sel;
   logic [IW-1:0] idx_d, idx_q;
   logic [W-1:0]  norm_d, norm_q;
   logic          zero_d, zero_q;

   assign adv2      = ~s2_vld_q | out_ready;
   assign adv1      = ~s1_vld_q | adv2;
   assign in_ready  = rst_n & adv1;
   assign out_valid = s2_vld_q;
   assign idx_o     = idx_q;
   assign norm_o    = norm_q;
   assign zero_o    = zero_q;

   // Group search: LOD scans upward so the last hit is the highest group, TOD scans downward.
   always_comb begin
      s1_d      = '0;
      s1_d.frac = frac_i;
      s1_d.mode = mode_i;
      for (int g = 0; g < NG; g++) begin
         s1_d.grp_or[g] = |frac_i[g*G +: G];
      end
      for (int g = 0; g < NG; g++) begin
         if (mode_i) begin
            if (s1_d.grp_or[NG-1-g]) s1_d.grp_idx = GIW'(NG-1-g);
         end else if (s1_d.grp_or[g]) begin
            s1_d.grp_idx = GIW'(g);
         end
      end
      for (int g = 0; g < NG; g++) begin
         if (GIW'(g) == s1_d.grp_idx) s1_d.grp_bits = frac_i[g*G +: G];
      end
   end

   always_comb begin
      bit_sel = '0;
      for (int b = 0; b < G; b++) begin
         if (s1_q.mode) begin
            if (s1_q.grp_bits[G-1-b]) bit_sel = BW'(G-1-b);
         end else if (s1_q.grp_bits[b]) begin
            bit_sel = BW'(b);
         end
      end
   end

   always_comb begin
      zero_d = ~|s1_q.grp_or;
      idx_d  = '0;
      norm_d = '0;
      if (!zero_d) begin
         idx_d  = IW'(s1_q.grp_idx) * IW'(G) + IW'(bit_sel);
         norm_d = s1_q.mode ? (s1_q.frac >> idx_d)
                            : (s1_q.frac << (IW'(W-1) - idx_d));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld_q <= 1'b0;
         s2_vld_q <= 1'b0;
         s1_q     <= '0;
         idx_q    <= '0;
         norm_q   <= '0;
         zero_q   <= 1'b0;
      end else begin
         if (adv1) s1_vld_q <= in_valid;
         if (adv1 && in_valid) s1_q <= s1_d;
         if (adv2) s2_vld_q <= s1_vld_q;
         if (adv2 && s1_vld_q) begin
            idx_q  <= idx_d;
            norm_q <= norm_d;
            zero_q <= zero_d;
         end
      end
   end
endmodule

// File: tb/tb_lod_norm_pipe.sv
// Scoreboard bench for lod_norm_pipe (W=12, G=4): directed vectors, backpressure,
// mid-flight reset and a random stream against a bit-serial reference model.
module tb_lod_norm_pipe;
   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, mode_i, out_valid, out_ready, zero_o;
   logic [11:0] frac_i, norm_o;
   logic [3:0]  idx_o;

   always #5 clk = ~clk;

   lod_norm_pipe #(.W(12), .G(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .frac_i(frac_i), .mode_i(mode_i), .out_valid(out_valid), .out_ready(out_ready),
      .idx_o(idx_o), .norm_o(norm_o), .zero_o(zero_o)
   );

   typedef struct {
      logic [3:0]  idx;
      logic [11:0] norm;
      logic        zero;
      int          cyc;
      bit          lat;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          total = 0, bad = 0, cyc = 0, emitted = 0;
   bit          hold_vld = 0;
   logic [3:0]  hold_idx;
   logic [11:0] hold_norm;
   logic        hold_zero;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] i, input logic [11:0] n, input logic z, input bit lat);
      exp_t e;
      e.idx = i; e.norm = n; e.zero = z; e.cyc = 0; e.lat = lat;
      return e;
   endfunction

   function automatic exp_t model(input logic [11:0] f, input logic m);
      exp_t e;
      int   p;
      e = mk(4'd0, 12'd0, (f == 12'd0), 1'b0);
      p = -1;
      for (int i = 0; i < 12; i++) begin
         if (f[i]) begin
            if (m) begin
               if (p < 0) p = i;
            end else p = i;
         end
      end
      if (p >= 0) begin
         e.idx  = 4'(p);
         e.norm = m ? (f >> p) : (f << (11 - p));
      end
      return e;
   endfunction

   task automatic push(input exp_t e);
      e.cyc = cyc;
      sb.push_back(e);
   endtask

   task automatic send(input logic [11:0] f, input logic m, input exp_t e);
      bit done = 0;
      in_valid = 1'b1; frac_i = f; mode_i = m;
      for (int t = 0; t < 40 && !done; t++) begin
         @(negedge clk);
         if (in_ready) begin
            push(e);
            done = 1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      for (int t = 0; t < 40 && sb.size() != 0; t++) @(negedge clk);
      chk("drain_empty", sb.size(), 32'd0);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (!rst_n) hold_vld = 0;
      else begin
         if (out_valid && !out_ready) begin
            if (hold_vld) begin
               chk("hold_idx", idx_o, hold_idx);
               chk("hold_norm", norm_o, hold_norm);
               chk("hold_zero", zero_o, hold_zero);
            end
            hold_vld = 1; hold_idx = idx_o; hold_norm = norm_o; hold_zero = zero_o;
         end else hold_vld = 0;
         if (out_valid && out_ready) begin
            emitted++;
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_out: got idx %0h norm %0h with no request pending", idx_o, norm_o);
            end else begin
               mon_e = sb.pop_front();
               chk("idx", idx_o, mon_e.idx);
               chk("norm", norm_o, mon_e.norm);
               chk("zero", zero_o, mon_e.zero);
               if (mon_e.lat) chk("latency", cyc - mon_e.cyc, 32'd2);
            end
         end
      end
   end

   logic [11:0] bp_f [4] = '{12'h400, 12'h00C, 12'h030, 12'h600};
   logic        bp_m [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   logic [3:0]  bp_i [4] = '{4'd10, 4'd2, 4'd5, 4'd9};
   logic [11:0] bp_n [4] = '{12'h800, 12'h003, 12'hC00, 12'h003};

   initial begin
      int k, gaps, stale, rnd_acc, e0;
      logic [11:0] f;
      logic m;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; frac_i = '0; mode_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 32'd0);
      chk("rst_idx", idx_o, 32'd0);
      chk("rst_norm", norm_o, 32'd0);
      chk("rst_zero", zero_o, 32'd0);
      chk("rst_in_ready", in_ready, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 32'd1);
      @(posedge clk); #1;

      // LOD basics, zero in both modes, TOD, back-to-back with mode changes
      send(12'h800, 1'b0, mk(4'd11, 12'h800, 1'b0, 1'b1));
      send(12'h0F0, 1'b0, mk(4'd7,  12'hF00, 1'b0, 1'b1));
      send(12'h001, 1'b0, mk(4'd0,  12'h800, 1'b0, 1'b1));
      send(12'h000, 1'b0, mk(4'd0,  12'h000, 1'b1, 1'b1));
      send(12'h000, 1'b1, mk(4'd0,  12'h000, 1'b1, 1'b1));
      send(12'h0A0, 1'b1, mk(4'd5,  12'h005, 1'b0, 1'b1));
      send(12'h801, 1'b1, mk(4'd0,  12'h801, 1'b0, 1'b1));
      send(12'h801, 1'b0, mk(4'd11, 12'h801, 1'b0, 1'b1));
      drain();

      // Backpressure: only two requests fit while the output is stalled
      out_ready = 1'b0; k = 0; in_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         frac_i = bp_f[k]; mode_i = bp_m[k];
         @(negedge clk);
         if (in_ready) begin
            push(mk(bp_i[k], bp_n[k], 1'b0, 1'b0));
            k++;
         end
         @(posedge clk); #1;
      end
      chk("bp_accepted", k, 32'd2);
      @(negedge clk);
      chk("bp_in_ready", in_ready, 32'd0);
      chk("bp_out_valid", out_valid, 32'd1);
      @(posedge clk); #1;
      out_ready = 1'b1; gaps = 0;
      for (int c = 0; c < 8; c++) begin
         if (k < 4) begin
            in_valid = 1'b1; frac_i = bp_f[k]; mode_i = bp_m[k];
         end else in_valid = 1'b0;
         @(negedge clk);
         if (in_valid && in_ready) begin
            push(mk(bp_i[k], bp_n[k], 1'b0, 1'b0));
            k++;
         end
         if (c < 4 && !out_valid) gaps++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("bp_all_accepted", k, 32'd4);
      chk("bp_gaps", gaps, 32'd0);
      drain();

      // Reset with both stages full discards in-flight work
      out_ready = 1'b0;
      send(12'h100, 1'b0, mk(4'd8, 12'h800, 1'b0, 1'b0));
      send(12'h002, 1'b1, mk(4'd1, 12'h001, 1'b0, 1'b0));
      @(negedge clk);
      chk("full_before_rst", out_valid, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("mid_rst_in_ready", in_ready, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_rst_out_valid", out_valid, 32'd0);
      chk("mid_rst_norm", norm_o, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("mid_rst_release_ready", in_ready, 32'd1);
      stale = 0;
      for (int c = 0; c < 5; c++) begin
         if (out_valid) stale++;
         @(negedge clk);
      end
      chk("no_stale_result", stale, 32'd0);
      @(posedge clk); #1;

      // Random stream against the reference model
      rnd_acc = 0; e0 = emitted;
      for (int c = 0; c < 400; c++) begin
         case ($urandom_range(0, 5))
            0: f = 12'h000;
            1: f = 12'h001 << $urandom_range(0, 11);
            default: f = 12'($urandom_range(0, 4095));
         endcase
         m = 1'($urandom_range(0, 1));
         in_valid = 1'($urandom_range(0, 1)); frac_i = f; mode_i = m;
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (in_valid && in_ready) begin
            push(model(f, m));
            rnd_acc++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      drain();
      chk("rnd_count", emitted - e0, rnd_acc);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lod_norm_pipe.md
LOD_NORM_PIPE -- requirements
Module: lod_norm_pipe

Interface
REQ-001 Parameter W, default 12: fraction width; SHALL be a multiple of G and at least 8.
REQ-002 Parameter G, default 4: group width for the two-level (group, then bit) priority search.
REQ-003 Derived constant IW = clog2(W): index width; 4 for the defaults.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  a request is offered on frac_i and mode_i.
REQ-007 in_ready  output  1  the block can accept a request this cycle.
REQ-008 frac_i  input  W  fraction to scan.
REQ-009 mode_i  input  1  0 selects leading-one detect (LOD); 1 selects trailing-one detect (TOD).
REQ-010 out_valid  output  1  the result outputs hold a valid result.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 idx_o  output  IW  bit position of the detected one, in the range W-1..0.
REQ-013 norm_o  output  W  normalised fraction.
REQ-014 zero_o  output  1  frac_i was all zeros.

Function
REQ-015 An input transfer SHALL occur when in_valid=1 and in_ready=1 are both high on a clock edge.
REQ-016 An output transfer SHALL occur when out_valid=1 and out_ready=1 are both high on a clock edge.
REQ-017 The datapath SHALL be a two-stage pipeline:
- S1 registers the per-group OR vector, the selected group, the group index, the original fraction and the mode.
- S2 registers idx_o, norm_o and zero_o.
REQ-018 The latency from input transfer to out_valid=1 SHALL be exactly 2 cycles when the pipeline is not stalled.
REQ-019 Throughput SHALL be 1 transfer per cycle while out_ready=1.
REQ-020 Group selection in LOD mode SHALL pick the highest-numbered group whose OR is 1; bit selection SHALL pick the highest set bit in that group.
REQ-021 Group selection in TOD mode SHALL pick the lowest-numbered group whose OR is 1; bit selection SHALL pick the lowest set bit in that group.
REQ-022 The index SHALL be computed as idx = G*group + bit, using unsigned IW-bit arithmetic with no overflow for legal W.
REQ-023 norm_o in LOD mode SHALL be frac_i shifted left by (W-1-idx), zero-filled, so that norm_o[W-1]=1.
REQ-024 norm_o in TOD mode SHALL be frac_i shifted right by idx, zero-filled, so that norm_o[0]=1.
REQ-025 For frac_i=0 the outputs SHALL be zero_o=1, idx_o=0 and norm_o=0 in either mode; otherwise zero_o=0.
REQ-026 Each stage SHALL advance when it is empty or when its downstream stage advances in the same cycle.
REQ-027 in_ready SHALL equal (S1 empty) OR (S2 empty) OR out_ready, and SHALL be purely combinational.
REQ-028 While out_valid=1 and out_ready=0, idx_o, norm_o and zero_o SHALL hold stable, and no accepted request SHALL be dropped or duplicated.
REQ-029 Results SHALL leave in the same order the requests were accepted.
REQ-030 Simultaneous input and output transfers on a full pipeline SHALL proceed without a bubble.
REQ-031 mode_i SHALL be captured per request; a mode change between back-to-back requests SHALL take effect only for the later request.

Reset
REQ-032 While rst_n=0 at a clock edge, both stage-valid flags SHALL clear to 0, including when the pipeline is mid-operation; in-flight requests SHALL be discarded.
REQ-033 The reset values SHALL be out_valid=0, idx_o=0, norm_o=0 and zero_o=0.
REQ-034 in_ready SHALL be 0 while rst_n=0, and SHALL be 1 in the first cycle after reset is released.
REQ-035 No output transfer SHALL occur until a new request has been accepted after reset.

Verification (W=12, G=4)
REQ-036 Scenario, LOD basics: 0x800 -> idx 11, norm 0x800; 0x0F0 -> idx 7, norm 0xF00; 0x001 -> idx 0, norm 0x800. Each result SHALL appear 2 cycles after acceptance with zero_o=0.
REQ-037 Scenario, zero input: 0x000 in LOD mode and in TOD mode -> zero_o=1, idx 0, norm 0x000.
REQ-038 Scenario, TOD: 0x0A0 -> idx 5, norm 0x005; 0x801 -> idx 0, norm 0x801.
REQ-039 Scenario, backpressure: hold out_ready=0 and offer 4 back-to-back requests -> exactly 2 accepted, then in_ready=0 and the outputs stay stable; release out_ready -> all 4 results emerge in order with no gaps.
REQ-040 Scenario, reset mid-flight: assert rst_n=0 with both stages full -> out_valid=0 on the next cycle; release reset -> in_ready=1 and no stale result appears.
REQ-041 Scenario, randomised stream: random frac_i, mode_i, in_valid and out_ready -> every result SHALL match a reference model, with the accepted count equal to the emitted count.
